// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared types, op encodings and chunk-count helper for the count sequencer
package cnt_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [1:0] CNT_CLZ = 2'b00;
    localparam logic [1:0] CNT_CTZ = 2'b01;
    localparam logic [1:0] CNT_POP = 2'b10;
    function automatic int num_chunks(input int n, input int c);
        return n / c;
    endfunction
endpackage

// File: rtl/cnt_seq_if.sv
// cnt_seq_if: request/response bundle of the count sequencer
// Start/Flush/A/B/W64 flow master->slave; Busy/Done/CntResult flow slave->master.
interface cnt_seq_if #(parameter int WIDTH = 64);
    logic             Start;
    logic             Flush;
    logic [WIDTH-1:0] A;
    logic [1:0]       B;
    logic             W64;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] CntResult;
    modport master (output Start, Flush, A, B, W64, input Busy, Done, CntResult);
    modport slave  (input Start, Flush, A, B, W64, output Busy, Done, CntResult);
endinterface

// File: rtl/cnt_seq_chunk.sv
// cnt_seq_chunk: combinational CHUNK-bit slice giving leading-zero count, popcount and nonzero flag
// Ports: i_chunk (slice bits), o_lzc (CHUNK when zero), o_pop, o_nz.
module cnt_seq_chunk #(
    parameter int CHUNK = 16,
    parameter int CW    = $clog2(CHUNK) + 1
) (
    input  logic [CHUNK-1:0] i_chunk,
    output logic [CW-1:0]    o_lzc,
    output logic [CW-1:0]    o_pop,
    output logic             o_nz
);
    always_comb begin
        o_lzc = CW'(CHUNK);
        o_pop = '0;
        // ascending scan: the last set bit seen is the most significant one
        for (int i = 0; i < CHUNK; i++) begin
            if (i_chunk[i]) o_lzc = CW'(CHUNK - 1 - i);
            o_pop = o_pop + CW'(i_chunk[i]);
        end
        o_nz = |i_chunk;
    end
endmodule

// File: rtl/cnt_seq.sv
// cnt_seq: multi-cycle clz/ctz/cpop sequencer iterating one CHUNK-bit slice MSB-chunk first
// Ports: clk, reset (async active-low), bus (cnt_seq_if.slave: Start/Flush/A/B/W64 in,
// Busy/Done/CntResult out). Optional macro CNT_SEQ_ZSKIP_EN: cpop stops once the rest of Op is zero.
module cnt_seq
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic     clk,
    input  logic     reset,
    cnt_seq_if.slave bus
);
    localparam int AW = $clog2(WIDTH) + 1;
    localparam int CW = $clog2(CHUNK) + 1;
    localparam int KF = num_chunks(WIDTH, CHUNK);
    localparam int KH = num_chunks(32, CHUNK);
    localparam int KW = $clog2(KF) + 1;
`ifdef CNT_SEQ_ZSKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif
    state_t           r_state;
    logic [WIDTH-1:0] r_op;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    r_res;
    logic [KW-1:0]    r_cnt;
    logic [KW-1:0]    r_last;
    logic             r_pop;
    logic             r_busy;
    logic             r_done;
    logic             w_word;
    logic             w_go;
    logic             w_fin;
    logic             w_nz;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_rest;
    logic [CW-1:0]    w_lzc;
    logic [CW-1:0]    w_popc;
    logic [AW-1:0]    w_acc;
    cnt_seq_chunk #(.CHUNK(CHUNK), .CW(CW)) u_chunk (
        .i_chunk (r_op[WIDTH-1 -: CHUNK]),
        .o_lzc   (w_lzc),
        .o_pop   (w_popc),
        .o_nz    (w_nz)
    );
    always_comb begin
        w_word = (WIDTH == 64) && bus.W64;
        w_mask = w_word ? (bus.A & WIDTH'(64'hFFFF_FFFF)) : bus.A;
        // reversing the masked operand puts a word's reversed low half at the top
        for (int i = 0; i < WIDTH; i++) w_rev[i] = w_mask[WIDTH-1-i];
        w_load = (bus.B == CNT_CTZ) ? w_rev : (w_word ? w_mask << (WIDTH - 32) : w_mask);
        w_go   = bus.Start && !bus.Flush;
        w_rest = r_op << CHUNK;
        w_acc  = r_acc + (r_pop ? AW'(w_popc) : AW'(w_lzc));
        w_fin  = (r_cnt == r_last) || (!r_pop && w_nz) || (ZSKIP && r_pop && w_rest == '0);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_pop   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (bus.Flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_op  <= w_rest;
                        r_cnt <= r_cnt + 1'b1;
                        r_acc <= w_acc;
                        if (w_fin) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_res   <= w_acc;
                        end
                    end
                end
                default: begin
                    if (w_go) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_op    <= w_load;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_last  <= w_word ? KW'(KH - 1) : KW'(KF - 1);
                        r_pop   <= (bus.B & CNT_POP) != 2'b00;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.CntResult = WIDTH'(r_res);
endmodule
